// File: rtl/duty_feeder.sv
// Sample FIFO feeding the PWM duty word: one pop per PWM period, midscale on underrun.
// Optional volume attenuation is compiled in with DUTY_FEEDER_VOLUME_EN.
module duty_feeder #(
  parameter int N     = 4,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic [N-1:0]             s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     pwm_step,
  input  logic                     vol_up,
  input  logic                     vol_dn,
  output logic [N-1:0]             duty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underrun
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [N-1:0] MID = {1'b1, {(N-1){1'b0}}};

  logic [N-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [N-1:0]  duty_q, duty_d;
  logic          underrun_q, underrun_d;
  logic [N-1:0]  rd_word, scaled;
  logic          push, pop_req, pop, empty;

  // Ready comes from the registered level, so a pop never frees a slot in the same cycle.
  assign empty   = (level_q == '0);
  assign s_ready = ena & (level_q < LW'(DEPTH));
  assign push    = s_valid & s_ready;
  assign pop_req = pwm_step & ena;
  assign pop     = pop_req & ~empty;
  assign rd_word = mem_q[rd_ptr_q];

`ifdef DUTY_FEEDER_VOLUME_EN
  logic [1:0]      vol_q, vol_d;
  logic signed [N:0] centred, shifted, sum;
  logic            unused_sum_msb;

  always_comb begin
    vol_d = vol_q;
    if (vol_up & ~vol_dn & (vol_q != 2'd0)) begin
      vol_d = vol_q - 2'd1;
    end else if (vol_dn & ~vol_up & (vol_q != 2'd3)) begin
      vol_d = vol_q + 2'd1;
    end
  end

  // Arithmetic shift floors toward -inf; the result always fits back into N bits.
  always_comb begin
    centred = $signed({1'b0, rd_word}) - $signed({1'b0, MID});
    shifted = centred >>> vol_q;
    sum     = shifted + $signed({1'b0, MID});
    scaled  = sum[N-1:0];
  end
  assign unused_sum_msb = sum[N];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vol_q <= '0;
    end else begin
      vol_q <= vol_d;
    end
  end
`else
  logic unused_vol;
  assign unused_vol = vol_up ^ vol_dn;
  assign scaled     = rd_word;
`endif

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    duty_d     = duty_q;
    underrun_d = 1'b0;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      duty_d   = scaled;
    end else if (pop_req) begin
      duty_d     = MID;
      underrun_d = 1'b1;
    end
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
  end

  // Storage needs no reset: level alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      duty_q     <= MID;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      duty_q     <= duty_d;
      underrun_q <= underrun_d;
    end
  end

  assign duty     = duty_q;
  assign level    = level_q;
  assign underrun = underrun_q;

endmodule

// File: doc/duty_feeder.md
# duty_feeder

Sample-buffer stage that sits directly upstream of the PWM generator in the amplifier datapath. It accepts audio samples through a valid/ready handshake and stores them in a small FIFO. On each PWM period boundary it pops one sample, applies an optional button-driven volume attenuation, and presents the result as the registered duty word the PWM stage consumes. On underrun it outputs midscale, which is 50 % duty and therefore silence.

## Interface
Parameters:
- N, 4, sample and duty width in bits; matches the PWM width.
- DEPTH, 8, FIFO depth in words; must be a power of 2 and ≥2.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ena  in  1  stage enable; low freezes pops and blocks pushes.
- s_data  in  N  unsigned sample, offset-binary (midscale = 2^(N-1)).
- s_valid  in  1  s_data is valid.
- s_ready  out  1  combinational: ena & (level < DEPTH).
- pwm_step  in  1  one-cycle pulse from the PWM stage at the start of each PWM period.
- vol_up  in  1  one-cycle pulse from the debounced button that decreases attenuation.
- vol_dn  in  1  one-cycle pulse from the debounced button that increases attenuation.
- duty  out  N  registered duty word to the PWM stage.
- level  out  $clog2(DEPTH)+1  current FIFO fill count.
- underrun  out  1  registered one-cycle pulse when a pop is requested on an empty FIFO.

## Operation
- Push: a word is accepted when s_valid & s_ready at a rising edge. It is written at wr_ptr, and wr_ptr increments modulo DEPTH.
- Pop request: pwm_step & ena.
  - If level > 0, read the word at rd_ptr, increment rd_ptr modulo DEPTH, and set duty <= scale(word).
  - If level = 0, set duty <= 2^(N-1) and pulse underrun.
- Level update: level is incremented on push only, decremented on successful pop only, and unchanged when both occur in the same cycle.
- Push into an empty FIFO in the same cycle as a pop request: the pop sees empty, so underrun fires and the pushed word is stored.
- Full FIFO: s_ready is low. A simultaneous pop does not raise s_ready in that cycle, because ready is computed from the registered level.
- Pointer width is $clog2(DEPTH). Full and empty are determined only from level.
- With ena low:
  - no pushes and no pops;
  - duty, FIFO contents, pointers and vol hold their values;
  - vol_up and vol_dn are still honoured.
- Volume state is vol, a 2-bit attenuation in the range 0..3.
  - vol_up decrements vol, saturating at 0.
  - vol_dn increments vol, saturating at 3.
  - If both pulses occur in the same cycle, vol does not change.
- scale(x) = 2^(N-1) + ((x − 2^(N-1)) >>> vol).
  - Compute in signed N+1 bits using an arithmetic shift, which floors toward −∞.
  - Truncate the result back to N bits. It is always in range, so no saturation is needed.
- A vol change affects only pops that occur after the change. It never retroactively alters the current duty.

## Timing
- Reset values (asynchronous, rst low): duty = 2^(N-1), level = 0, pointers = 0, vol = 0, underrun = 0.
- Reset applied mid-operation discards all FIFO contents immediately.
- duty updates on the rising edge that samples pwm_step high. The new value is visible in the cycle after the pulse, so the PWM stage latches it one cycle into its period.
- A word accepted at edge k is poppable from edge k+1 onward.
- underrun is high for exactly the one cycle following the failing pop edge.
- level and s_ready reflect a push or pop in the cycle after the edge on which it occurred.

## Configuration
- Macro: DUTY_FEEDER_VOLUME_EN.
- Defined: vol register and scale() are as described above.
- Undefined: vol is absent and scale(x) = x.
  - vol_up and vol_dn remain as ports but are ignored.
  - Datapath is unchanged otherwise, with no added latency.

## Test plan
With N=4, DEPTH=8, VOLUME_EN defined:
- Reset then idle: after rst released, expect duty=8, level=0, s_ready=1. A pwm_step on the empty FIFO gives underrun=1 for one cycle and duty stays 8.
- Fill/full: push 8 words 0..7 back-to-back, expect level=8 and s_ready=0. A ninth s_valid is not accepted. Then 8 pwm_steps give duty 0,1,…,7 in order and level returns to 0.
- Volume scaling:
  - vol_dn once (vol=1), push 12, pwm_step gives duty=10.
  - vol_dn again (vol=2), push 2, pwm_step gives duty=6.
  - Four further vol_dn saturate vol at 3. Then push 15 and pwm_step: duty=8+(7>>>3)=8.
- Simultaneous events:
  - Push and pwm_step in the same cycle at level=3: level stays 3.
  - Same at level=0: underrun pulses and level becomes 1.
  - vol_up with vol_dn in the same cycle: vol unchanged.
- Enable/reset: with level=4, drop ena. pwm_step has no effect and s_ready=0. Raise ena, then assert rst mid-stream: duty=8 and level=0 immediately, without waiting for a clock edge.
- VOLUME_EN undefined build: vol_dn pulses, push 12, pwm_step gives duty=12.
